// File: rtl/adder_pipe_if.sv
// Operand/result handshake bundle for adder_pipe.
// The master side drives operands and consumes results; the slave side is the adder.
interface adder_pipe_if #(
  parameter int unsigned WIDTH = 16
);
  logic             inValid;
  logic             inReady;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             carryIn;
  logic             sub;
  logic             outValid;
  logic             outReady;
  logic [WIDTH-1:0] sum;
  logic             carryOut;
  logic             overflow;

  modport master (
    output inValid, a, b, carryIn, sub, outReady,
    input  inReady, outValid, sum, carryOut, overflow
  );

  modport slave (
    input  inValid, a, b, carryIn, sub, outReady,
    output inReady, outValid, sum, carryOut, overflow
  );
endinterface

// File: rtl/adder_pipe.sv
// Pipelined add/subtract unit. Operands are split into SEG_WIDTH-bit segments;
// stage k adds segment k and registers the carry into stage k+1. Unconsumed
// operand segments and completed result segments ride along in skew registers.
// All stages advance together when the output slot is empty or being taken.
// Optional macro ADDER_PIPE_SATURATE_EN clamps the result to the signed extreme
// on overflow in the final stage (latency unchanged).
module adder_pipe #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned SEG_WIDTH = 4
) (
  input logic         clk,
  input logic         resetN,
  adder_pipe_if.slave bus
);

  localparam int unsigned STAGES = WIDTH / SEG_WIDTH;
  localparam int unsigned MSB    = WIDTH - 1;
  localparam int unsigned SEG_W1 = SEG_WIDTH + 1;

  // One in-flight beat: operands (b already conditioned), partial result, carry.
  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] bp;
    logic [WIDTH-1:0] s;
    logic             c;
  } stage_t;

  // Adds segment k of a and bp plus the incoming carry; segment k of s must be zero on entry.
  function automatic stage_t add_seg(input stage_t st, input int unsigned k);
    logic [SEG_WIDTH:0] t;
    stage_t             o;
    o = st;
    t = {1'b0, SEG_WIDTH'(st.a >> (k * SEG_WIDTH))}
      + {1'b0, SEG_WIDTH'(st.bp >> (k * SEG_WIDTH))}
      + SEG_W1'(st.c);
    o.s = st.s | (WIDTH'(t[SEG_WIDTH-1:0]) << (k * SEG_WIDTH));
    o.c = t[SEG_WIDTH];
    return o;
  endfunction

  logic             adv;
  stage_t           head;
  stage_t           tail;
  stage_t           last_st;
  logic             last_ovf;
  logic [WIDTH-1:0] last_sum;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] sum_q,       sum_d;
  logic             carry_q,     carry_d;
  logic             ovf_q,       ovf_d;

  // Whole pipe advances when the output slot is empty or its beat is being taken.
  assign adv = !out_valid_q || bus.outReady;

  assign bus.inReady  = adv;
  assign bus.outValid = out_valid_q;
  assign bus.sum      = sum_q;
  assign bus.carryOut = carry_q;
  assign bus.overflow = ovf_q;

  // Condition operands for the selected mode: subtract is a + ~b + 1.
  always_comb begin
    head       = '0;
    head.valid = bus.inValid;
    head.a     = bus.a;
    head.bp    = bus.sub ? ~bus.b : bus.b;
    head.c     = bus.sub ? 1'b1 : bus.carryIn;
  end

  if (STAGES > 1) begin : g_skew
    stage_t pipe_q [STAGES-1];
    stage_t pipe_d [STAGES-1];

    // Segment stages 0..STAGES-2; bubbles shift like valid beats.
    always_comb begin
      for (int unsigned k = 0; k < STAGES - 1; k++) begin
        pipe_d[k] = pipe_q[k];
      end
      if (adv) begin
        pipe_d[0] = add_seg(head, 0);
        for (int unsigned k = 1; k < STAGES - 1; k++) begin
          pipe_d[k] = add_seg(pipe_q[k-1], k);
        end
      end
    end

    // Skew/carry registers with synchronous clear.
    always_ff @(posedge clk) begin
      for (int unsigned k = 0; k < STAGES - 1; k++) begin
        if (!resetN) begin
          pipe_q[k] <= '0;
        end else begin
          pipe_q[k] <= pipe_d[k];
        end
      end
    end

    assign tail = pipe_q[STAGES-2];
  end else begin : g_flat
    assign tail = head;
  end

  // Final segment, overflow detection and optional clamp feeding the output registers.
  always_comb begin
    last_st  = add_seg(tail, STAGES - 1);
    last_ovf = (last_st.a[MSB] == last_st.bp[MSB]) && (last_st.s[MSB] != last_st.a[MSB]);
    last_sum = last_st.s;
`ifdef ADDER_PIPE_SATURATE_EN
    if (last_ovf) begin
      last_sum = last_st.a[MSB] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
`endif
    out_valid_d = out_valid_q;
    sum_d       = sum_q;
    carry_d     = carry_q;
    ovf_d       = ovf_q;
    if (adv) begin
      out_valid_d = last_st.valid;
      sum_d       = last_sum;
      carry_d     = last_st.c;
      ovf_d       = last_ovf;
    end
  end

  // Output registers; held while the result is stalled.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      sum_q       <= sum_d;
      carry_q     <= carry_d;
      ovf_q       <= ovf_d;
    end
  end

endmodule

// File: tb/tb_adder_pipe.sv
// Scoreboard bench for adder_pipe (16-bit, 4-bit segments).
module tb_adder_pipe;

  localparam int unsigned W      = 16;
  localparam int unsigned SEG    = 4;
  localparam int unsigned STAGES = W / SEG;

`ifdef ADDER_PIPE_SATURATE_EN
  localparam logic [W-1:0] EXP_SUB_OVF = 16'h8000;
  localparam logic [W-1:0] EXP_ADD_OVF = 16'h7FFF;
`else
  localparam logic [W-1:0] EXP_SUB_OVF = 16'h7FFF;
  localparam logic [W-1:0] EXP_ADD_OVF = 16'h8000;
`endif

  typedef struct packed {
    logic [W-1:0] sum;
    logic         co;
    logic         ov;
  } exp_t;

  logic clk = 1'b0;
  logic resetN;
  always #5 clk = ~clk;

  adder_pipe_if #(.WIDTH(W)) bus ();

  adder_pipe #(.WIDTH(W), .SEG_WIDTH(SEG)) dut (
    .clk    (clk),
    .resetN (resetN),
    .bus    (bus)
  );

  exp_t sb [$];
  int   n_checks;
  int   n_errs;
  logic mon_en;
  logic stalled;
  exp_t held;
  exp_t got;
  logic burst_done;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Whole-word reference: a + b + cin, or a + ~b + 1 for subtract.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic cin, input logic sb_mode);
    logic [W:0]   r;
    logic [W-1:0] bp;
    exp_t         e;
    bp   = sb_mode ? ~b : b;
    r    = {1'b0, a} + {1'b0, bp} + (W+1)'(sb_mode ? 1'b1 : cin);
    e.co = r[W];
    e.ov = (a[W-1] == bp[W-1]) && (r[W-1] != a[W-1]);
    e.sum = r[W-1:0];
`ifdef ADDER_PIPE_SATURATE_EN
    if (e.ov) e.sum = a[W-1] ? 16'h8000 : 16'h7FFF;
`endif
    return e;
  endfunction

  // Output monitor: stall hold, inReady during stall, scoreboard pop on transfer.
  always @(negedge clk) begin
    if (mon_en) begin
      if (stalled) begin
        check_val("hold", 32'({bus.outValid, bus.sum, bus.carryOut, bus.overflow}), 32'({1'b1, held}));
      end
      held.sum = bus.sum;
      held.co  = bus.carryOut;
      held.ov  = bus.overflow;
      if (bus.outValid && !bus.outReady) begin
        check_val("inready_stall", 32'(bus.inReady), 32'(0));
      end
      if (bus.outValid && bus.outReady) begin
        if (sb.size() == 0) begin
          check_val("spurious_out", 32'(bus.outValid), 32'(0));
        end else begin
          got = sb.pop_front();
          check_val("sum", 32'(bus.sum), 32'(got.sum));
          check_val("carry_out", 32'(bus.carryOut), 32'(got.co));
          check_val("overflow", 32'(bus.overflow), 32'(got.ov));
        end
      end
      stalled = bus.outValid && !bus.outReady;
    end else begin
      stalled = 1'b0;
    end
  end

  // Present one beat until accepted; returns 1 time unit after the accepting edge.
  task automatic drive_beat(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic cin, input logic sb_mode, input exp_t e);
    logic acc;
    acc         = 1'b0;
    bus.a       = a;
    bus.b       = b;
    bus.carryIn = cin;
    bus.sub     = sb_mode;
    bus.inValid = 1'b1;
    for (int n = 0; n < 200 && !acc; n++) begin
      @(negedge clk);
      acc = bus.inReady;
      @(posedge clk);
    end
    if (acc) sb.push_back(e);
    else check_val("accept_timeout", 32'(bus.inReady), 32'(1));
    #1;
  endtask

  task automatic drive_rand();
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sm;
    a   = W'($urandom);
    b   = W'($urandom);
    cin = 1'($urandom);
    sm  = 1'($urandom);
    drive_beat(a, b, cin, sm, model(a, b, cin, sm));
  endtask

  // Checks outValid stays low for STAGES-1 cycles after acceptance and rises on the last.
  task automatic check_latency();
    for (int i = 1; i <= int'(STAGES); i++) begin
      @(negedge clk);
      check_val("latency", 32'(bus.outValid), 32'(i == int'(STAGES)));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_directed(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                              input logic sb_mode, input logic [W-1:0] s, input logic co,
                              input logic ov);
    exp_t e;
    e.sum = s;
    e.co  = co;
    e.ov  = ov;
    drive_beat(a, b, cin, sb_mode, e);
    bus.inValid = 1'b0;
    check_latency();
  endtask

  task automatic wait_drain();
    for (int n = 0; n < 200 && sb.size() != 0; n++) @(posedge clk);
    check_val("drain", 32'(sb.size()), 32'(0));
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks    = 0;
    n_errs      = 0;
    mon_en      = 1'b0;
    stalled     = 1'b0;
    burst_done  = 1'b0;
    resetN      = 1'b0;
    bus.inValid = 1'b0;
    bus.a       = '0;
    bus.b       = '0;
    bus.carryIn = 1'b0;
    bus.sub     = 1'b0;
    bus.outReady = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_out_valid", 32'(bus.outValid), 32'(0));
    check_val("rst_sum", 32'(bus.sum), 32'(0));
    check_val("rst_carry_out", 32'(bus.carryOut), 32'(0));
    check_val("rst_overflow", 32'(bus.overflow), 32'(0));
    check_val("rst_in_ready", 32'(bus.inReady), 32'(1));
    resetN = 1'b1;
    mon_en = 1'b1;
    @(posedge clk);
    #1;

    // Directed vectors with latency checks.
    run_directed(16'h0110, 16'h0047, 1'b0, 1'b0, 16'h0157, 1'b0, 1'b0);
    run_directed(16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_directed(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    run_directed(16'h8000, 16'h0001, 1'b0, 1'b1, EXP_SUB_OVF, 1'b1, 1'b1);
    run_directed(16'h7FFF, 16'h0001, 1'b0, 1'b0, EXP_ADD_OVF, 1'b0, 1'b1);
    wait_drain();

    // Six back-to-back beats; downstream stalls while results 2-4 are presented.
    fork
      begin
        for (int i = 0; i < 6; i++) drive_rand();
        bus.inValid = 1'b0;
      end
      begin
        int n;
        n = 0;
        while (!bus.outValid && n < 50) begin
          @(posedge clk);
          #1;
          n++;
        end
        if (n >= 50) check_val("stall_wait", 32'(bus.outValid), 32'(1));
        @(posedge clk);
        #1;
        bus.outReady = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        bus.outReady = 1'b1;
      end
    join
    wait_drain();

    // Random traffic with input gaps and random downstream backpressure.
    burst_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 60; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            bus.inValid = 1'b0;
            @(posedge clk);
            #1;
          end
          drive_rand();
        end
        bus.inValid = 1'b0;
        burst_done  = 1'b1;
      end
      begin
        while (!burst_done) begin
          @(posedge clk);
          #1;
          bus.outReady = ($urandom_range(0, 3) != 0);
        end
        bus.outReady = 1'b1;
      end
    join
    wait_drain();

    // Reset with three beats in flight: nothing stale may emerge.
    for (int i = 0; i < 3; i++) drive_rand();
    bus.inValid = 1'b0;
    mon_en      = 1'b0;
    resetN      = 1'b0;
    @(posedge clk);
    #1;
    check_val("inflight_rst_out_valid", 32'(bus.outValid), 32'(0));
    check_val("inflight_rst_sum", 32'(bus.sum), 32'(0));
    check_val("inflight_rst_carry_out", 32'(bus.carryOut), 32'(0));
    check_val("inflight_rst_overflow", 32'(bus.overflow), 32'(0));
    resetN = 1'b1;
    sb.delete();
    mon_en = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    run_directed(16'h1234, 16'h0FF1, 1'b1, 1'b0, 16'h2226, 1'b0, 1'b0);
    wait_drain();

    check_val("scoreboard_empty", 32'(sb.size()), 32'(0));
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/adder_pipe.md
Name: adder_pipe

Overview:
Parametrised, pipelined add/subtract unit; the next generation of the fixed 16-bit combinational full adder. Operands are split into SEG_WIDTH-bit segments; each pipeline stage adds one segment and registers the carry into the next stage. The unit uses a valid/ready handshake with global stall. It is the adder primitive for the accelerator datapath (MAC accumulate, address generation).

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of SEG_WIDTH.
SEG_WIDTH, 4, bits added per pipeline stage; STAGES = WIDTH/SEG_WIDTH (default 4).

Ports:
clk  input  1  clock; all state on rising edge
resetN  input  1  synchronous active-low reset
inValid  input  1  operand beat valid
inReady  output  1  unit accepts a beat this cycle
a  input  WIDTH  operand A
b  input  WIDTH  operand B
carryIn  input  1  carry input; used in add mode only
sub  input  1  0 = a+b+carryIn, 1 = a-b
outValid  output  1  result beat valid
outReady  input  1  downstream accepts the result
sum  output  WIDTH  result
carryOut  output  1  add: carry out of MSB; sub: 1 = no borrow (a >= b unsigned)
overflow  output  1  signed two's-complement overflow

Behaviour:
- Reset: synchronous, active-low. Sampled on the clk edge. Clears every stage valid bit. Result: outValid=0, sum=0, carryOut=0, overflow=0 on the cycle after. In-flight beats are discarded; none is emitted after reset.
- Advance enable: adv = !outValid || outReady. All stages shift together when adv=1. When adv=0, all stages hold: no bubble collapse, no data change.
- Handshake:
  - inReady = adv. A beat is accepted when inValid && inReady.
  - A result transfers when outValid && outReady.
  - outValid/sum/carryOut/overflow are stable while outValid && !outReady.
- Latency: STAGES cycles from acceptance to outValid, with no stall. Throughput is 1 beat/cycle.
- Datapath:
  - Sub mode uses b' = ~b and c0 = 1. Add mode uses b' = b and c0 = carryIn.
  - Stage k adds segment k of a and b' plus the registered carry from stage k-1 (c0 for stage 0).
  - Upper unconsumed operand segments are carried forward in skew registers. Completed lower result segments are carried forward as well.
  - carryOut is the carry from the top segment.
  - overflow = (a[MSB] == b'[MSB]) && (sum[MSB] != a[MSB]). The raw pre-saturation sum is used.
- Bubbles: stages holding invalid beats still shift. Their data is don't-care and must not affect valid beats.
- Simultaneous accept and emit with adv=1 is legal every cycle. Order is strictly preserved.
- Wrap-around: results are modulo 2^WIDTH unless saturation is compiled in.
- STAGES=1 is legal: single registered adder, latency 1.

Optional Feature:
Macro ADDER_PIPE_SATURATE_EN.
- Defined: when overflow=1, sum is clamped to the signed extreme. Positive overflow gives 0111..1; negative overflow gives 1000..0. carryOut and overflow report the unclamped operation. Clamping is applied in the final stage, so latency is unchanged.
- Undefined: sum wraps; no clamp logic is present.

Test Plan:
- WIDTH=16/SEG=4, add, a=0x0110, b=0x0047, carryIn=0, outReady=1 -> after 4 cycles sum=0x0157, carryOut=0, overflow=0.
- add, a=0xFFFF, b=0x0000, carryIn=1 -> sum=0x0000, carryOut=1, overflow=0 (carry ripples through all 4 stages).
- sub, a=0x0005, b=0x0007 -> sum=0xFFFE, carryOut=0 (borrow), overflow=0. Also a=0x8000, b=0x0001 -> sum=0x7FFF, overflow=1 (0x8000 when saturated).
- add, a=0x7FFF, b=0x0001, carryIn=0 -> overflow=1. sum=0x8000 without macro, 0x7FFF with ADDER_PIPE_SATURATE_EN.
- 6 back-to-back beats, with outReady low during result cycles 2-4 -> inReady=0 while stalled, output held stable, all 6 results emitted in order, none lost or duplicated.
- 3 beats in flight, resetN=0 for one cycle -> outValid=0 the next cycle and no stale results afterwards. A new beat after reset returns correctly after 4 cycles.
